// File: rtl/soft_processor_memory_arbiter.sv
// soft_processor_memory_arbiter
// Shares one single-port on-chip memory between the Nios data master (port 0)
// and the telemetry/DMA master (port 1). Arbitration is zero-cycle and round-robin
// per transfer. Read returns are steered by a tag pipeline that matches the
// memory's fixed read latency.
module soft_processor_memory_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  input  logic                freeze,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W = DATA_W / 8;

  logic req0;
  logic req1;
  logic grant0;
  logic grant1;
  logic granted;
  logic last_grant;
  logic win_write;
  logic accept_read;

  logic [READ_LATENCY-1:0] pipe_valid;
  logic [READ_LATENCY-1:0] pipe_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Round-robin grant: contention goes to the port that did not win last time
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!freeze) begin
      if (req0 && req1) begin
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  assign granted     = grant0 | grant1;
  assign win_write   = grant1 ? m1_write : m0_write;
  assign accept_read = granted & ~win_write;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  // Memory-side mux; port 0 steers the don't-care fields when nobody is granted
  always_comb begin
    mem_address    = grant1 ? m1_address   : m0_address;
    mem_writedata  = grant1 ? m1_writedata : m0_writedata;
    mem_byteenable = {BE_W{1'b1}};
    if (win_write) mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    mem_chipselect = granted;
    mem_write      = granted & win_write;
  end

  assign mem_clken = 1'b1;

  // Arbitration history and read-return tag pipeline; reset drops in-flight reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      pipe_valid <= '0;
      pipe_owner <= '0;
    end else begin
      if (granted) last_grant <= grant1;
      pipe_valid[0] <= accept_read;
      pipe_owner[0] <= grant1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_owner[i] <= pipe_owner[i-1];
      end
    end
  end

  assign m0_readdatavalid = pipe_valid[READ_LATENCY-1] & ~pipe_owner[READ_LATENCY-1];
  assign m1_readdatavalid = pipe_valid[READ_LATENCY-1] &  pipe_owner[READ_LATENCY-1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_soft_processor_memory_arbiter.sv
// Testbench for soft_processor_memory_arbiter with READ_LATENCY=2.
// A behavioural memory preloaded with 0xC0DE0000 | address answers the arbiter.
module tb_soft_processor_memory_arbiter;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int RL     = 2;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [3:0]        m0_byteenable, m1_byteenable;
  logic              m0_read, m1_read, m0_write, m1_write;
  logic [31:0]       m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [31:0]       m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic              freeze;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [31:0]       mem_writedata, mem_readdata;

  int n_checks;
  int n_fails;

  soft_processor_memory_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .freeze(freeze),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: byte-lane writes, RL-cycle registered reads
  logic [31:0] mem [0:32767];
  logic [31:0] rd_pipe [0:1];

  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = 32'hC0DE_0000 | a;
  end

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        rd_pipe[0] <= mem[mem_address];
      end
    end
    rd_pipe[1] <= rd_pipe[0];
  end

  assign mem_readdata = rd_pipe[1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    freeze = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
  endtask

  task automatic test_reset();
    idle();
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    reset_n = 0;
    step();
    @(negedge clk);
    n_checks++; if (m0_readdatavalid !== 1'b0) begin n_fails++; $display("FAIL reset_m0_rdv: got %b expected 0", m0_readdatavalid); end
    n_checks++; if (m1_readdatavalid !== 1'b0) begin n_fails++; $display("FAIL reset_m1_rdv: got %b expected 0", m1_readdatavalid); end
    n_checks++; if (mem_chipselect !== 1'b0) begin n_fails++; $display("FAIL reset_cs: got %b expected 0", mem_chipselect); end
    n_checks++; if (mem_clken !== 1'b1) begin n_fails++; $display("FAIL reset_clken: got %b expected 1", mem_clken); end
    step();
    reset_n = 1;
    step();
  endtask

  task automatic test_single_read();
    m0_read = 1; m0_address = 15'h0010;
    @(negedge clk);
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_fails++; $display("FAIL single_wait: got %b expected 0", m0_waitrequest); end
    n_checks++; if (mem_chipselect !== 1'b1) begin n_fails++; $display("FAIL single_cs: got %b expected 1", mem_chipselect); end
    n_checks++; if (mem_address !== 15'h0010) begin n_fails++; $display("FAIL single_addr: got %h expected 0010", mem_address); end
    n_checks++; if (mem_write !== 1'b0) begin n_fails++; $display("FAIL single_wr: got %b expected 0", mem_write); end
    step();
    idle();
    @(negedge clk);
    n_checks++; if (m0_readdatavalid !== 1'b0) begin n_fails++; $display("FAIL single_early_rdv: got %b expected 0", m0_readdatavalid); end
    step();
    @(negedge clk);
    n_checks++; if (m0_readdatavalid !== 1'b1) begin n_fails++; $display("FAIL single_rdv: got %b expected 1", m0_readdatavalid); end
    n_checks++; if (m0_readdata !== 32'hC0DE0010) begin n_fails++; $display("FAIL single_data: got %h expected C0DE0010", m0_readdata); end
    n_checks++; if (m1_readdatavalid !== 1'b0) begin n_fails++; $display("FAIL single_m1_rdv: got %b expected 0", m1_readdatavalid); end
    step();
    @(negedge clk);
    n_checks++; if (m0_readdatavalid !== 1'b0) begin n_fails++; $display("FAIL single_late_rdv: got %b expected 0", m0_readdatavalid); end
    step();
  endtask

  task automatic test_contention();
    logic [14:0] exp_addr;
    logic        exp_rdv0, exp_rdv1;
    int          j;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 6) begin
        m0_read = 1; m0_address = 15'h0100 + 15'((i + 1) / 2);
        m1_read = 1; m1_address = 15'h0200 + 15'(i / 2);
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 6) begin
        exp_addr = ((i % 2) == 0) ? 15'h0100 + 15'(i / 2) : 15'h0200 + 15'(i / 2);
        n_checks++; if (m0_waitrequest !== ((i % 2) == 1)) begin n_fails++; $display("FAIL cont_wait0 c%0d: got %b expected %b", i, m0_waitrequest, (i % 2) == 1); end
        n_checks++; if (m1_waitrequest !== ((i % 2) == 0)) begin n_fails++; $display("FAIL cont_wait1 c%0d: got %b expected %b", i, m1_waitrequest, (i % 2) == 0); end
        n_checks++; if (mem_address !== exp_addr) begin n_fails++; $display("FAIL cont_addr c%0d: got %h expected %h", i, mem_address, exp_addr); end
      end
      exp_rdv0 = 0; exp_rdv1 = 0;
      if (i >= RL) begin
        j = i - RL;
        exp_rdv0 = (j % 2) == 0;
        exp_rdv1 = (j % 2) == 1;
        exp_addr = ((j % 2) == 0) ? 15'h0100 + 15'(j / 2) : 15'h0200 + 15'(j / 2);
        if (exp_rdv0) begin
          n_checks++; if (m0_readdata !== (32'hC0DE0000 | 32'(exp_addr))) begin n_fails++; $display("FAIL cont_data0 c%0d: got %h expected %h", i, m0_readdata, 32'hC0DE0000 | 32'(exp_addr)); end
        end else begin
          n_checks++; if (m1_readdata !== (32'hC0DE0000 | 32'(exp_addr))) begin n_fails++; $display("FAIL cont_data1 c%0d: got %h expected %h", i, m1_readdata, 32'hC0DE0000 | 32'(exp_addr)); end
        end
      end
      n_checks++; if (m0_readdatavalid !== exp_rdv0) begin n_fails++; $display("FAIL cont_rdv0 c%0d: got %b expected %b", i, m0_readdatavalid, exp_rdv0); end
      n_checks++; if (m1_readdatavalid !== exp_rdv1) begin n_fails++; $display("FAIL cont_rdv1 c%0d: got %b expected %b", i, m1_readdatavalid, exp_rdv1); end
      step();
    end
  endtask

  task automatic test_byteenable_write();
    idle();
    m1_write = 1; m1_address = 15'h7FFF; m1_writedata = 32'hDEADBEEF; m1_byteenable = 4'b0011;
    @(negedge clk);
    n_checks++; if (m1_waitrequest !== 1'b0) begin n_fails++; $display("FAIL be_wait1: got %b expected 0", m1_waitrequest); end
    n_checks++; if (mem_write !== 1'b1) begin n_fails++; $display("FAIL be_wr: got %b expected 1", mem_write); end
    n_checks++; if (mem_byteenable !== 4'b0011) begin n_fails++; $display("FAIL be_wr_be: got %b expected 0011", mem_byteenable); end
    n_checks++; if (mem_writedata !== 32'hDEADBEEF) begin n_fails++; $display("FAIL be_wdata: got %h expected DEADBEEF", mem_writedata); end
    step();
    idle();
    m0_read = 1; m0_address = 15'h7FFF; m0_byteenable = 4'b0000;
    @(negedge clk);
    n_checks++; if (mem_byteenable !== 4'b1111) begin n_fails++; $display("FAIL be_rd_be: got %b expected 1111", mem_byteenable); end
    n_checks++; if (mem_write !== 1'b0) begin n_fails++; $display("FAIL be_rd_wr: got %b expected 0", mem_write); end
    step();
    idle();
    step();
    @(negedge clk);
    n_checks++; if (m0_readdatavalid !== 1'b1) begin n_fails++; $display("FAIL be_rdv: got %b expected 1", m0_readdatavalid); end
    n_checks++; if (m0_readdata !== 32'hC0DEBEEF) begin n_fails++; $display("FAIL be_data: got %h expected C0DEBEEF", m0_readdata); end
    step();
  endtask

  task automatic test_freeze();
    idle();
    m0_read = 1; m0_address = 15'h0030;
    @(negedge clk);
    n_checks++; if (m0_waitrequest !== 1'b0) begin n_fails++; $display("FAIL frz_first_wait: got %b expected 0", m0_waitrequest); end
    step();
    for (int i = 1; i <= 5; i++) begin
      freeze = 1;
      m0_read = 1; m0_address = 15'h0031;
      m1_read = 1; m1_address = 15'h0231;
      @(negedge clk);
      n_checks++; if (mem_chipselect !== 1'b0) begin n_fails++; $display("FAIL frz_cs c%0d: got %b expected 0", i, mem_chipselect); end
      n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin n_fails++; $display("FAIL frz_wait c%0d: got %b expected 11", i, {m0_waitrequest, m1_waitrequest}); end
      n_checks++; if (m0_readdatavalid !== (i == RL)) begin n_fails++; $display("FAIL frz_rdv c%0d: got %b expected %b", i, m0_readdatavalid, i == RL); end
      if (i == RL) begin
        n_checks++; if (m0_readdata !== 32'hC0DE0030) begin n_fails++; $display("FAIL frz_data: got %h expected C0DE0030", m0_readdata); end
      end
      step();
    end
    freeze = 0;
    @(negedge clk);
    n_checks++; if (mem_chipselect !== 1'b1) begin n_fails++; $display("FAIL frz_resume_cs: got %b expected 1", mem_chipselect); end
    n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin n_fails++; $display("FAIL frz_resume_wait: got %b expected 10", {m0_waitrequest, m1_waitrequest}); end
    step();
    idle();
    step();
    @(negedge clk);
    n_checks++; if (m1_readdatavalid !== 1'b1) begin n_fails++; $display("FAIL frz_m1_rdv: got %b expected 1", m1_readdatavalid); end
    n_checks++; if (m1_readdata !== 32'hC0DE0231) begin n_fails++; $display("FAIL frz_m1_data: got %h expected C0DE0231", m1_readdata); end
    step();
  endtask

  task automatic test_reset_midflight();
    idle();
    m1_read = 1; m1_address = 15'h0041;
    step();
    idle();
    m0_read = 1; m0_address = 15'h0040;
    step();
    idle();
    reset_n = 0;
    @(negedge clk);
    n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_fails++; $display("FAIL mid_rst_rdv: got %b expected 00", {m0_readdatavalid, m1_readdatavalid}); end
    step();
    reset_n = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin n_fails++; $display("FAIL mid_post_rdv c%0d: got %b expected 00", i, {m0_readdatavalid, m1_readdatavalid}); end
      step();
    end
    m0_read = 1; m0_address = 15'h0050;
    m1_read = 1; m1_address = 15'h0051;
    @(negedge clk);
    n_checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin n_fails++; $display("FAIL mid_first_win: got %b expected 01", {m0_waitrequest, m1_waitrequest}); end
    step();
    idle();
    step();
    step();
  endtask

  task automatic test_read_write_together();
    idle();
    m0_read = 1; m0_write = 1; m0_address = 15'h0020; m0_writedata = 32'h12345678;
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1) begin n_fails++; $display("FAIL rw_wr: got %b expected 1", mem_write); end
    n_checks++; if (mem_writedata !== 32'h12345678) begin n_fails++; $display("FAIL rw_wdata: got %h expected 12345678", mem_writedata); end
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (m0_readdatavalid !== 1'b0) begin n_fails++; $display("FAIL rw_no_rdv c%0d: got %b expected 0", i, m0_readdatavalid); end
      step();
    end
    m0_read = 1; m0_address = 15'h0020;
    step();
    idle();
    step();
    @(negedge clk);
    n_checks++; if (m0_readdata !== 32'h12345678) begin n_fails++; $display("FAIL rw_readback: got %h expected 12345678", m0_readdata); end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_byteenable_write();
    test_freeze();
    test_reset_midflight();
    test_read_write_together();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/soft_processor_memory_arbiter.md
# soft_processor_memory_arbiter

Two-master arbiter for the soft processor's 32K x 32 single-port on-chip memory. It shares the memory between the Nios data master (port 0) and the telemetry/DMA master (port 1) with per-transfer round-robin grant. Read data is returned through a tag pipeline matched to the memory's fixed read latency. A freeze input stops new grants while in-flight reads drain.

## Interface
Parameters:
- ADDR_W, 15, word address width (32768 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- READ_LATENCY, 1, memory cycles from accepted read to valid mem_readdata; legal values 1..4

Ports:
- clk  in  1  sole clock
- reset_n  in  1  reset, asynchronous assert, active-low
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes for writes
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle (combinational)
- m0_readdata / m1_readdata  out  DATA_W  returned read data
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle
- freeze  in  1  block new grants; in-flight reads complete
- mem_address  out  ADDR_W  to memory
- mem_byteenable  out  DATA_W/8  to memory; forced to all-ones on reads
- mem_chipselect  out  1  asserted on the granted cycle only
- mem_write  out  1  write strobe of the granted transfer
- mem_writedata  out  DATA_W  to memory
- mem_clken  out  1  memory clock enable; tied 1
- mem_readdata  in  DATA_W  from memory

## Operation
- Request on port n: req_n = mn_read | mn_write. If read and write are asserted together, the transfer is a write.
- Grant is computed combinationally each cycle from req_0, req_1, freeze and the last_grant register.
  - One requester, no freeze: that requester is granted.
  - Both requesting: the port not equal to last_grant is granted.
  - freeze=1: no grant.
- mn_waitrequest = req_n & ~grant_n. A port with no request drives waitrequest 0.
- Granted transfer: mem_chipselect=1. mem_address, mem_write and mem_writedata are muxed from the winner. mem_byteenable comes from the winner on writes and is all-ones on reads.
- No grant: mem_chipselect=0, mem_write=0. Other mem_* outputs are don't-care and are driven from port 0.
- last_grant is updated on every accepted transfer, read or write.
- Read return tracking:
  - A READ_LATENCY-deep shift register carries {valid, owner} per cycle. A granted read inserts {1, winner}; any other cycle inserts {0, x}.
  - At the output stage, mn_readdatavalid = valid & (owner==n).
  - mn_readdata is a direct copy of mem_readdata on both ports; validity is given by readdatavalid only.
- Reads are fully pipelined: a new read is accepted every cycle regardless of outstanding reads. Writes carry no response.
- freeze does not stall the shift register. Reads accepted before freeze still return.

## Timing
- Reset values: last_grant=1, so port 0 wins the first contention. All shift-register valid bits are 0, so both readdatavalid outputs are 0.
- Reset asserted mid-operation: in-flight reads are discarded and no readdatavalid is issued for them. Combinational outputs follow inputs.
- Zero-cycle arbitration: a request asserted in cycle t with no contender is accepted in cycle t (waitrequest low in t).
- Read accepted in cycle t: readdatavalid on the owning port in cycle t+READ_LATENCY.
- Back-to-back contention alternates 0,1,0,1 on successive cycles.
- A lone requester is granted every cycle; last_grant still tracks it.
- Simultaneous events:
  - freeze rising in the same cycle as a request: that request is stalled.
  - freeze falling: grants resume in the same cycle.
  - A read return and a new grant in the same cycle are independent.
- Throughput: one transfer per clk. Max outstanding reads = READ_LATENCY.

## Test plan
- After reset, m0 reads addr 0x0010 alone (m1 idle) -> m0_waitrequest=0 in the same cycle; m0_readdatavalid=1 exactly READ_LATENCY cycles later with the mem model's word; m1_readdatavalid stays 0.
- m0 and m1 both hold reads for 6 cycles (m0 addr 0x100+, m1 addr 0x200+) -> grants 0,1,0,1,0,1; each requester sees waitrequest=1 on alternate cycles; returns interleave with the correct data per owner.
- m1 writes 0xDEADBEEF with byteenable 4'b0011 to addr 0x7FFF, then m0 reads 0x7FFF -> mem_byteenable=0011 on the write and 1111 on the read; m0 gets 0x????BEEF, upper half preserved.
- Read accepted at cycle t, freeze asserted at t+1 for 5 cycles with both ports requesting -> data for t returns at t+READ_LATENCY; no mem_chipselect during freeze; both waitrequests high; grants resume on the first cycle after freeze falls.
- reset_n pulsed low while 2 reads are outstanding (READ_LATENCY=2) -> no readdatavalid for either; after release, port 0 wins the first contention.
- m0 asserts read and write together with data 0x12345678 to addr 0x0020 -> a write is issued (mem_write=1); no readdatavalid follows.
